disp_hex_scan: RTL and testbench

Parametrised multi-digit, multi-page hex display scanner for the board's 7-segment outputs. It replaces the fixed 4-digit hex decode and LED mux chain, and the external halfword select, with one registered block. The block snapshots a DATA_W-bit value once per scan frame, then time-multiplexes NUM_DIGITS digits. It supports manual or automatic page cycling across wider words, per-digit decimal points and blanking. It sits between the system's gpO outputs and the LEDSEL/LEDOUT pins.

---
 rtl/disp_hex_scan.sv | 206 ++++++++++++++++++++
 tb/tb_disp_hex_scan.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/disp_hex_scan.sv
// rtl/disp_hex_scan.sv - multi-digit, multi-page 7-segment hex display scanner
//
// Snapshots a DATA_W-bit word once per scan frame and time-multiplexes
// NUM_DIGITS hex digits onto a shared segment bus. Pages of 4*NUM_DIGITS
// bits are selected manually or cycled automatically every AUTO_FRAMES frames.
// Optional build macro: LZ_BLANK_EN (leading-zero blanking on the shown page).
//
// Ports:
//   clk        scan clock
//   rst        asynchronous active-high reset
//   data       word to display (sampled at frame end)
//   dp         per-digit decimal point, 1 = lit (sampled at frame end)
//   page_sel   manual page index, clamped to the last page
//   auto_page  1 = advance page automatically
//   blank      1 = all digits dark on the next cycle
//   LEDSEL     anode enables (one-cold when ACTIVE_LOW=1)
//   LEDOUT     segments {dp,g,f,e,d,c,b,a}
//   page_cur   page currently displayed
//   frame_tick one-cycle pulse in the cycle after frame end

module disp_hex_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int DATA_W      = 32,
  parameter int REFRESH_DIV = 1,
  parameter int AUTO_FRAMES = 2500,
  parameter int ACTIVE_LOW  = 1,
  localparam int NUM_PAGES  = DATA_W / (4 * NUM_DIGITS),
  localparam int PAGE_W     = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     data,
  input  logic [NUM_DIGITS-1:0] dp,
  input  logic [PAGE_W-1:0]     page_sel,
  input  logic                  auto_page,
  input  logic                  blank,
  output logic [NUM_DIGITS-1:0] LEDSEL,
  output logic [7:0]            LEDOUT,
  output logic [PAGE_W-1:0]     page_cur,
  output logic                  frame_tick
);

  localparam int DIV_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int AUTO_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam int PG_BITS = 4 * NUM_DIGITS;

  localparam logic [NUM_DIGITS-1:0] SEL_OFF = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [7:0]            SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  // Active-low segment patterns {dp,g,f,e,d,c,b,a}; dp bit is off here.
  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_seg = 8'hC0;
      4'h1: hex_seg = 8'hF9;
      4'h2: hex_seg = 8'hA4;
      4'h3: hex_seg = 8'hB0;
      4'h4: hex_seg = 8'h99;
      4'h5: hex_seg = 8'h92;
      4'h6: hex_seg = 8'h82;
      4'h7: hex_seg = 8'hF8;
      4'h8: hex_seg = 8'h80;
      4'h9: hex_seg = 8'h90;
      4'hA: hex_seg = 8'h88;
      4'hB: hex_seg = 8'h83;
      4'hC: hex_seg = 8'hC6;
      4'hD: hex_seg = 8'hA1;
      4'hE: hex_seg = 8'h86;
      default: hex_seg = 8'h8E;
    endcase
  endfunction

  logic [DIV_W-1:0]      divcnt_q, divcnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]     snap_data_q, snap_data_d;
  logic [NUM_DIGITS-1:0] snap_dp_q, snap_dp_d;
  logic [PAGE_W-1:0]     page_q, page_d;
  logic [AUTO_W-1:0]     autocnt_q, autocnt_d;
  logic                  frame_tick_q, frame_tick_d;
  logic [NUM_DIGITS-1:0] ledsel_q, ledsel_d;
  logic [7:0]            ledout_q, ledout_d;

  logic                  div_wrap;
  logic                  frame_end;
  logic [PAGE_W-1:0]     page_clamp;
  logic [PG_BITS-1:0]    page_word;
  logic [3:0]            nib;
  logic                  dp_bit;
  logic [NUM_DIGITS-1:0] sel_al;
  logic [7:0]            seg_al;
`ifdef LZ_BLANK_EN
  logic                  lz_hide;
`endif

  // Scan counters, frame snapshot and page control.
  always_comb begin
    divcnt_d     = divcnt_q;
    idx_d        = idx_q;
    snap_data_d  = snap_data_q;
    snap_dp_d    = snap_dp_q;
    page_d       = page_q;
    autocnt_d    = autocnt_q;

    div_wrap     = (divcnt_q == DIV_W'(REFRESH_DIV - 1));
    frame_end    = div_wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));
    frame_tick_d = frame_end;

    // Equality search keeps the clamp free of always-true/false compares
    // when NUM_PAGES is a power of two.
    page_clamp = PAGE_W'(NUM_PAGES - 1);
    for (int p = 0; p < NUM_PAGES; p++) begin
      if (page_sel == PAGE_W'(p)) page_clamp = PAGE_W'(p);
    end

    divcnt_d = div_wrap ? '0 : divcnt_q + 1'b1;
    if (div_wrap) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    if (frame_end) begin
      snap_data_d = data;
      snap_dp_d   = dp;
      if (NUM_PAGES > 1) begin
        if (!auto_page) begin
          page_d    = page_clamp;
          autocnt_d = '0;
        end else if (autocnt_q == AUTO_W'(AUTO_FRAMES - 1)) begin
          autocnt_d = '0;
          page_d    = (page_q == PAGE_W'(NUM_PAGES - 1)) ? '0 : page_q + 1'b1;
        end else begin
          autocnt_d = autocnt_q + 1'b1;
        end
      end
    end
  end

  // Output decode from the current digit, snapshot and page.
  always_comb begin
    page_word = '0;
    for (int p = 0; p < NUM_PAGES; p++) begin
      if (page_q == PAGE_W'(p)) page_word = snap_data_q[p*PG_BITS +: PG_BITS];
    end

    nib    = '0;
    dp_bit = 1'b0;
`ifdef LZ_BLANK_EN
    lz_hide = 1'b0;
`endif
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (idx_q == IDX_W'(d)) begin
        nib    = page_word[4*d +: 4];
        dp_bit = snap_dp_q[d];
`ifdef LZ_BLANK_EN
        // Hidden when this nibble and every one above it are zero; digit 0
        // and digits with a lit dp are always shown.
        lz_hide = (d != 0) && !snap_dp_q[d] && ((page_word >> (4*d)) == '0);
`endif
      end
    end

    seg_al = hex_seg(nib);
    if (dp_bit) seg_al[7] = 1'b0;
`ifdef LZ_BLANK_EN
    if (lz_hide) seg_al = 8'hFF;
`endif
    sel_al = ~(NUM_DIGITS'(1) << idx_q);

    if (blank) begin
      sel_al = '1;
      seg_al = 8'hFF;
    end

    ledsel_d = (ACTIVE_LOW != 0) ? sel_al : ~sel_al;
    ledout_d = (ACTIVE_LOW != 0) ? seg_al : ~seg_al;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divcnt_q     <= '0;
      idx_q        <= '0;
      snap_data_q  <= '0;
      snap_dp_q    <= '0;
      page_q       <= '0;
      autocnt_q    <= '0;
      frame_tick_q <= 1'b0;
      ledsel_q     <= SEL_OFF;
      ledout_q     <= SEG_OFF;
    end else begin
      divcnt_q     <= divcnt_d;
      idx_q        <= idx_d;
      snap_data_q  <= snap_data_d;
      snap_dp_q    <= snap_dp_d;
      page_q       <= page_d;
      autocnt_q    <= autocnt_d;
      frame_tick_q <= frame_tick_d;
      ledsel_q     <= ledsel_d;
      ledout_q     <= ledout_d;
    end
  end

  assign LEDSEL     = ledsel_q;
  assign LEDOUT     = ledout_q;
  assign page_cur   = page_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_disp_hex_scan.sv
// tb/tb_disp_hex_scan.sv - directed self-checking bench for disp_hex_scan

module tb_disp_hex_scan;

`ifdef LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic [3:0]  dp;
  logic [0:0]  page_sel;
  logic        auto_page;
  logic        blank;

  logic [3:0]  ledsel, ledsel_n, ledsel3;
  logic [7:0]  ledout, ledout_n, ledout3;
  logic [0:0]  page_cur, page_cur_n;
  logic [1:0]  page_cur3;
  logic        ftick, ftick_n, ftick3;
  logic [47:0] data3;
  logic [1:0]  page_sel3;

  int n_cmp = 0;
  int n_bad = 0;

  assign data3     = {16'h0000, data};
  assign page_sel3 = 2'd3;

  always #5 clk = ~clk;

  disp_hex_scan #(.NUM_DIGITS(4), .DATA_W(32), .REFRESH_DIV(2), .AUTO_FRAMES(2), .ACTIVE_LOW(1)) u_dut (
    .clk(clk), .rst(rst), .data(data), .dp(dp), .page_sel(page_sel), .auto_page(auto_page),
    .blank(blank), .LEDSEL(ledsel), .LEDOUT(ledout), .page_cur(page_cur), .frame_tick(ftick)
  );

  disp_hex_scan #(.NUM_DIGITS(4), .DATA_W(32), .REFRESH_DIV(2), .AUTO_FRAMES(2), .ACTIVE_LOW(0)) u_dut_n (
    .clk(clk), .rst(rst), .data(data), .dp(dp), .page_sel(page_sel), .auto_page(auto_page),
    .blank(blank), .LEDSEL(ledsel_n), .LEDOUT(ledout_n), .page_cur(page_cur_n), .frame_tick(ftick_n)
  );

  // Three pages: lets an out-of-range page_sel actually be expressed.
  disp_hex_scan #(.NUM_DIGITS(4), .DATA_W(48), .REFRESH_DIV(2), .AUTO_FRAMES(2), .ACTIVE_LOW(1)) u_dut3 (
    .clk(clk), .rst(rst), .data(data3), .dp(dp), .page_sel(page_sel3), .auto_page(1'b0),
    .blank(blank), .LEDSEL(ledsel3), .LEDOUT(ledout3), .page_cur(page_cur3), .frame_tick(ftick3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks both polarities of the display against active-low expectations.
  task automatic chk_disp(input string tag, input logic [3:0] sel, input logic [7:0] seg);
    logic [3:0] sel_n;
    logic [7:0] seg_n;
    sel_n = ~sel;
    seg_n = ~seg;
    chk({tag, "_sel"},   32'(ledsel),   32'(sel));
    chk({tag, "_seg"},   32'(ledout),   32'(seg));
    chk({tag, "_sel_n"}, 32'(ledsel_n), 32'(sel_n));
    chk({tag, "_seg_n"}, 32'(ledout_n), 32'(seg_n));
  endtask

  // Entered at the negedge right after a frame end (or reset release);
  // returns at the negedge right after the following frame end.
  task automatic check_frame(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                             input logic [7:0] e3, input logic pg, input string tag);
    logic [7:0] e [4];
    logic [3:0] s;
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s = ~(4'b0001 << i);
      chk_disp($sformatf("%s_d%0d", tag, i), s, e[i]);
      chk($sformatf("%s_d%0d_page", tag, i), 32'(page_cur), 32'(pg));
      chk($sformatf("%s_d%0d_tick", tag, i), 32'(ftick), 32'd0);
      @(negedge clk);
    end
    chk({tag, "_tick_end"}, 32'(ftick), 32'd1);
  endtask

  task automatic wait_tick(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clk);
      seen = ftick;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    rst = 1'b1; data = 32'h0; dp = 4'h0; page_sel = 1'b0; auto_page = 1'b0; blank = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Reset mid-scan takes effect without a clock edge.
    rst = 1'b1;
    #1;
    chk_disp("reset", 4'hF, 8'hFF);
    chk("reset_page", 32'(page_cur), 32'd0);
    chk("reset_tick", 32'(ftick), 32'd0);
    repeat (2) @(negedge clk);

    data = 32'h1234_ABCD;
    rst  = 1'b0;
    check_frame(8'hC0, LZ ? 8'hFF : 8'hC0, LZ ? 8'hFF : 8'hC0, LZ ? 8'hFF : 8'hC0, 1'b0, "first");
    chk("clamp3_page", 32'(page_cur3), 32'd2);

    // Manual paging; page_sel change is only seen at the next frame end.
    page_sel = 1'b1;
    check_frame(8'hA1, 8'hC6, 8'h83, 8'h88, 1'b0, "pg0");
    data = 32'h0000_1111; page_sel = 1'b0;
    check_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 1'b1, "pg1");

    // Anti-tearing: data changes right after the snapshot.
    data = 32'h0000_2222;
    check_frame(8'hF9, 8'hF9, 8'hF9, 8'hF9, 1'b0, "tear_old");
    dp = 4'b0010;
    check_frame(8'hA4, 8'hA4, 8'hA4, 8'hA4, 1'b0, "tear_new");

    // Blank for three cycles, then resume at the running digit.
    blank = 1'b1;
    @(negedge clk); chk_disp("blank1", 4'hF, 8'hFF);
    @(negedge clk); chk_disp("blank2", 4'hF, 8'hFF);
    @(negedge clk); chk_disp("blank3", 4'hF, 8'hFF);
    blank = 1'b0;
    @(negedge clk); chk_disp("unblank_d1", 4'hD, 8'h24);
    @(negedge clk); chk_disp("unblank_d2", 4'hB, 8'hA4);
    wait_tick("blank_resync");

    // Auto paging: 0,0,1,1,0 across consecutive frames.
    data = 32'h1234_ABCD; dp = 4'h0; auto_page = 1'b1;
    check_frame(8'hA4, 8'h24, 8'hA4, 8'hA4, 1'b0, "dp");
    check_frame(8'hA1, 8'hC6, 8'h83, 8'h88, 1'b0, "auto_a");
    check_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 1'b1, "auto_b");
    check_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 1'b1, "auto_c");
    auto_page = 1'b0; page_sel = 1'b1;
    check_frame(8'hA1, 8'hC6, 8'h83, 8'h88, 1'b0, "auto_d");
    data = 32'h0000_0050; page_sel = 1'b0;
    check_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 1'b1, "manual_back");

    // Leading zeros (blanked only in the LZ_BLANK_EN build).
    data = 32'h0;
    check_frame(8'hC0, 8'h92, LZ ? 8'hFF : 8'hC0, LZ ? 8'hFF : 8'hC0, 1'b0, "lz50");
    check_frame(8'hC0, LZ ? 8'hFF : 8'hC0, LZ ? 8'hFF : 8'hC0, LZ ? 8'hFF : 8'hC0, 1'b0, "lz0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
